pll_lock_sequencer: RTL and testbench

Sequences and supervises the on-chip PLL from the reference-clock domain. It holds the PLL in reset for a fixed interval, waits for a stable lock with a timeout and bounded retries, and opens the downstream clock enable only while lock is held. It re-sequences automatically on loss of lock and accepts divider reconfiguration through a valid/ready handshake. It sits between the system reset/config logic and the PLL macro (`reset`, divider, `Locked`).

---
 rtl/pll_lock_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings up and supervises the PLL from the reference-clock domain. Each
//   attempt holds the PLL in reset for RST_CYCLES, then waits for a run of
//   STABLE_CYCLES consecutive synchronised lock samples within LOCK_TIMEOUT
//   cycles. A failed attempt is retried MAX_RETRY times before the sequencer
//   parks in FAIL. While LOCKED the downstream clock enable is open. A drop of
//   lock re-sequences from reset. Divider updates are taken through a
//   valid/ready handshake in LOCKED or FAIL and always restart the sequence.
//
// Ports
//   clk_ref        in   reference clock (only clock)
//   reset          in   asynchronous active-high reset
//   pll_locked     in   raw PLL lock flag, asynchronous to clk_ref
//   cfg_valid      in   divider update request
//   cfg_div        in   requested divider (0 is clamped to 1)
//   cfg_ready      out  update accepted when cfg_valid & cfg_ready
//   pll_rst        out  reset to the PLL macro
//   pll_div        out  feedback divider to the PLL macro
//   clk_en         out  downstream clock-gate enable
//   status_locked  out  sequencer is in LOCKED
//   status_fail    out  sequencer is in FAIL
//   retry_cnt      out  retries used in the current sequence
//   lock_loss_cnt  out  saturating count of lock losses
module pll_lock_sequencer #(
    parameter int DIV_W         = 8,
    parameter int DIV_DEFAULT   = 16,
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int MAX_RETRY     = 3
) (
    input  logic             clk_ref,
    input  logic             reset,
    input  logic             pll_locked,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             pll_rst,
    output logic [DIV_W-1:0] pll_div,
    output logic             clk_en,
    output logic             status_locked,
    output logic             status_fail,
    output logic [1:0]       retry_cnt,
    output logic [7:0]       lock_loss_cnt
);

    localparam logic [1:0] ST_RST    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAIL   = 2'd3;

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int TC_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [RC_W-1:0]  RST_LAST     = RC_W'(RST_CYCLES - 1);
    localparam logic [SC_W-1:0]  STABLE_LAST  = SC_W'(STABLE_CYCLES - 1);
    localparam logic [TC_W-1:0]  TIMEOUT_LAST = TC_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);
    localparam logic [DIV_W-1:0] DIV_RESET    = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] DIV_MIN      = DIV_W'(1);

    logic [1:0]      state;
    logic [RC_W-1:0] rst_cnt;
    logic [SC_W-1:0] stable_cnt;
    logic [TC_W-1:0] timeout_cnt;
    logic            lock_meta;
    logic            lock_s;
    logic            xfer;

    // A zero feedback divider is meaningless to the PLL macro.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_MIN : d;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // All status outputs are pure decodes of the state register.
    assign pll_rst       = (state == ST_RST) || (state == ST_FAIL);
    assign clk_en        = (state == ST_LOCKED);
    assign status_locked = (state == ST_LOCKED);
    assign status_fail   = (state == ST_FAIL);
    assign cfg_ready     = (state == ST_LOCKED) || (state == ST_FAIL);
    assign xfer          = cfg_valid & cfg_ready;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            state         <= ST_RST;
            rst_cnt       <= '0;
            stable_cnt    <= '0;
            timeout_cnt   <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_div       <= DIV_RESET;
        end else begin
            case (state)
                ST_RST: begin
                    stable_cnt  <= '0;
                    timeout_cnt <= '0;
                    // rst_cnt is left at zero on exit so the next entry
                    // into RST, from any state, starts a full interval.
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt <= '0;
                        state   <= ST_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    stable_cnt  <= lock_s ? stable_cnt + 1'b1 : '0;
                    // Lock completion is tested first so it wins a tie
                    // with the timeout.
                    if (lock_s && (stable_cnt == STABLE_LAST)) begin
                        state     <= ST_LOCKED;
                        retry_cnt <= '0;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ST_RST;
                        end else begin
                            state <= ST_FAIL;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!lock_s) begin
                        lock_loss_cnt <= sat_inc8(lock_loss_cnt);
                        state         <= ST_RST;
                    end
                end
                ST_FAIL: begin
                end
                default: state <= ST_RST;
            endcase

            // A divider transfer overrides any transition chosen above; the
            // lock-loss count update in the same cycle is still kept.
            if (xfer) begin
                pll_div   <= clamp_div(cfg_div);
                retry_cnt <= '0;
                state     <= ST_RST;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int DIV_W         = 8;
    localparam int DIV_DEFAULT   = 16;
    localparam int RST_CYCLES    = 4;
    localparam int STABLE_CYCLES = 8;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int MAX_RETRY     = 2;

    logic             clk_ref    = 1'b0;
    logic             reset      = 1'b1;
    logic             pll_locked = 1'b0;
    logic             cfg_valid  = 1'b0;
    logic [DIV_W-1:0] cfg_div    = '0;
    logic             cfg_ready;
    logic             pll_rst;
    logic [DIV_W-1:0] pll_div;
    logic             clk_en;
    logic             status_locked;
    logic             status_fail;
    logic [1:0]       retry_cnt;
    logic [7:0]       lock_loss_cnt;

    pll_lock_sequencer #(
        .DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEFAULT), .RST_CYCLES(RST_CYCLES),
        .STABLE_CYCLES(STABLE_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_ref(clk_ref), .reset(reset), .pll_locked(pll_locked),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
        .pll_rst(pll_rst), .pll_div(pll_div), .clk_en(clk_en),
        .status_locked(status_locked), .status_fail(status_fail),
        .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
    );

    always #500 clk_ref = ~clk_ref;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase-level view of a bring-up sequence.
    typedef enum int {M_HOLD, M_WAIT, M_LOCKED, M_FAIL} mphase_t;
    mphase_t m_phase;
    int      m_hold_n;
    bit      m_wls[$];
    int      m_retry;
    int      m_llc;
    int      m_div;
    bit      m_s1, m_s2;

    function automatic void model_enter_hold();
        m_phase  = M_HOLD;
        m_hold_n = 0;
    endfunction

    function automatic void model_reset();
        model_enter_hold();
        m_wls.delete();
        m_retry = 0;
        m_llc   = 0;
        m_div   = DIV_DEFAULT;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
    endfunction

    function automatic void model_step();
        bit lk;
        bit xfer;
        bit stable_run;
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        xfer = cfg_valid && (m_phase == M_LOCKED || m_phase == M_FAIL);
        case (m_phase)
            M_HOLD: begin
                m_hold_n++;
                if (m_hold_n == RST_CYCLES) begin
                    m_phase = M_WAIT;
                    m_wls.delete();
                end
            end
            M_WAIT: begin
                m_wls.push_back(lk);
                stable_run = (m_wls.size() >= STABLE_CYCLES);
                for (int i = 0; i < STABLE_CYCLES && stable_run; i++)
                    if (!m_wls[m_wls.size() - 1 - i]) stable_run = 1'b0;
                if (stable_run) begin
                    m_phase = M_LOCKED;
                    m_retry = 0;
                end else if (m_wls.size() == LOCK_TIMEOUT) begin
                    if (m_retry < MAX_RETRY) begin
                        m_retry++;
                        model_enter_hold();
                    end else begin
                        m_phase = M_FAIL;
                    end
                end
            end
            M_LOCKED: begin
                if (!lk) begin
                    if (m_llc < 255) m_llc++;
                    model_enter_hold();
                end
            end
            default: ;
        endcase
        if (xfer) begin
            m_div   = (cfg_div == 0) ? 1 : int'(cfg_div);
            m_retry = 0;
            model_enter_hold();
        end
    endfunction

    initial forever begin
        @(posedge clk_ref or posedge reset);
        if (reset) begin
            model_reset();
            cyc = 0;
        end else begin
            model_step();
            cyc++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk_ref);
        chk("pll_rst",       pll_rst,       (m_phase == M_HOLD) || (m_phase == M_FAIL));
        chk("clk_en",        clk_en,        m_phase == M_LOCKED);
        chk("status_locked", status_locked, m_phase == M_LOCKED);
        chk("status_fail",   status_fail,   m_phase == M_FAIL);
        chk("cfg_ready",     cfg_ready,     (m_phase == M_LOCKED) || (m_phase == M_FAIL));
        chk("retry_cnt",     retry_cnt,     m_retry);
        chk("lock_loss_cnt", lock_loss_cnt, m_llc);
        chk("pll_div",       pll_div,       m_div);
    end

    initial begin
        #60000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic till(input int k);
        while (cyc < k) @(negedge clk_ref);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pll_rst"},  pll_rst,       1);
        chk({tag, "_pll_div"},  pll_div,       DIV_DEFAULT);
        chk({tag, "_clk_en"},   clk_en,        0);
        chk({tag, "_locked"},   status_locked, 0);
        chk({tag, "_fail"},     status_fail,   0);
        chk({tag, "_ready"},    cfg_ready,     0);
        chk({tag, "_retry"},    retry_cnt,     0);
        chk({tag, "_llc"},      lock_loss_cnt, 0);
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is visible.
    task automatic apply_reset(input string tag);
        @(negedge clk_ref);
        #100;
        reset = 1'b1;
        #1;
        check_reset_vals(tag);
        @(negedge clk_ref);
        @(negedge clk_ref);
        reset = 1'b0;
    endtask

    task automatic wait_locked(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (status_locked) break;
            @(negedge clk_ref);
        end
        chk("wait_lock", status_locked, 1);
    endtask

    initial begin
        int mode;
        int len;

        // Basic bring-up
        pll_locked = 1'b0;
        apply_reset("rst0");
        till(3);  chk("t1_rst_hold", pll_rst, 1);
        till(4);  chk("t1_rst_low", pll_rst, 0);
        till(9);  pll_locked = 1'b1;
        till(18); chk("t1_not_yet", status_locked, 0);
        till(19); chk("t1_locked", status_locked, 1);
                  chk("t1_clk_en", clk_en, 1);
                  chk("t1_retry", retry_cnt, 0);

        // One-cycle lock loss while LOCKED
        till(30); pll_locked = 1'b0;
        till(31); pll_locked = 1'b1;
        till(32); chk("t3_clk_en_hold", clk_en, 1);
        till(33); chk("t3_clk_en_drop", clk_en, 0);
                  chk("t3_pll_rst", pll_rst, 1);
                  chk("t3_llc", lock_loss_cnt, 1);
        till(44); chk("t3_relock_early", status_locked, 0);
        till(45); chk("t3_relock", status_locked, 1);

        // Divider reconfiguration
        till(50); cfg_valid = 1'b1; cfg_div = 8'h25;
        till(51); cfg_valid = 1'b0;
                  chk("t4_div", pll_div, 8'h25);
                  chk("t4_ready", cfg_ready, 0);
                  chk("t4_pll_rst", pll_rst, 1);
                  chk("t4_clk_en", clk_en, 0);
        till(63); chk("t4_relock", status_locked, 1);
        till(70); cfg_valid = 1'b1; cfg_div = 8'h00;
        till(71); cfg_valid = 1'b0;
                  chk("t4_div_clamp", pll_div, 1);
        till(76); cfg_valid = 1'b1; cfg_div = 8'h33;
        till(78); chk("t4_wait_ready", cfg_ready, 0);
        till(80); cfg_valid = 1'b0;
                  chk("t4_wait_noxfer", pll_div, 1);
        till(83); chk("t4_relock2", status_locked, 1);

        // Timeouts, retries and FAIL
        pll_locked = 1'b0;
        apply_reset("rst1");
        till(67);  chk("t2_retry0", retry_cnt, 0);
        till(68);  chk("t2_retry1", retry_cnt, 1);
                   chk("t2_att2_rst", pll_rst, 1);
        till(72);  chk("t2_att2_wait", pll_rst, 0);
        till(136); chk("t2_retry2", retry_cnt, 2);
        till(203); chk("t2_not_fail", status_fail, 0);
        till(204); chk("t2_fail", status_fail, 1);
                   chk("t2_fail_rst", pll_rst, 1);
                   chk("t2_fail_ready", cfg_ready, 1);
                   chk("t2_fail_clk_en", clk_en, 0);
        till(210); cfg_valid = 1'b1; cfg_div = 8'h40;
        till(211); cfg_valid = 1'b0;
                   chk("t2_exit_fail", status_fail, 0);
                   chk("t2_exit_retry", retry_cnt, 0);
                   chk("t2_exit_div", pll_div, 8'h40);

        // Periodic lock glitches, then lock completing on the timeout cycle
        apply_reset("rst2");
        for (int k = 1; k <= 68; k++) begin
            till(k - 1);
            pll_locked = (k % 5) != 0;
        end
        till(67); chk("t5_never_locks", status_locked, 0);
        till(68); chk("t5_retry1", retry_cnt, 1);
        for (int k = 69; k <= 125; k++) begin
            till(k - 1);
            pll_locked = (k % 5) != 0;
        end
        till(125); pll_locked = 1'b0;
        till(126); pll_locked = 1'b1;
        till(135); chk("t5_tie_before", status_locked, 0);
        till(136); chk("t5_tie_lock_wins", status_locked, 1);
                   chk("t5_tie_retry", retry_cnt, 0);

        // Async reset mid-WAIT_LOCK and mid-LOCKED
        till(140); pll_locked = 1'b0;
        till(141); pll_locked = 1'b1;
        till(150);
        apply_reset("rst_wait");
        till(14); cfg_valid = 1'b1; cfg_div = 8'h5A;
        till(15); cfg_valid = 1'b0;
        till(27); chk("t6_locked_div", pll_div, 8'h5A);
                  chk("t6_locked", status_locked, 1);
        till(30);
        apply_reset("rst_locked");

        // Lock-loss counter saturation
        wait_locked(40);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_ref); pll_locked = 1'b0;
            @(negedge clk_ref); pll_locked = 1'b1;
            repeat (3) @(negedge clk_ref);
            wait_locked(40);
        end
        chk("t6_llc_sat", lock_loss_cnt, 255);

        // Randomised traffic
        apply_reset("rst_rand");
        for (int c = 0; c < 15; c++) begin
            mode = $urandom_range(0, 2);
            len  = $urandom_range(100, 400);
            for (int j = 0; j < len; j++) begin
                @(negedge clk_ref);
                case (mode)
                    0:       pll_locked = ($urandom_range(0, 39) != 0);
                    1:       pll_locked = 1'b0;
                    default: pll_locked = 1'($urandom_range(0, 1));
                endcase
                cfg_valid = ($urandom_range(0, 29) == 0);
                cfg_div   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            end
        end
        cfg_valid = 1'b0;
        @(negedge clk_ref);
        @(negedge clk_ref);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
